// File: rtl/pair_eval_scheduler.sv
// Round-robin scheduler for two requesters sharing a select-driven operand evaluator.
// Each grant sweeps select 0 (bank A) then select 1 (bank B) and returns both passes on one response.
module pair_eval_scheduler #(
  parameter int NPAIR = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2*NPAIR-1:0]   req0_a,
  input  logic [2*NPAIR-1:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2*NPAIR-1:0]   req1_a,
  input  logic [2*NPAIR-1:0]   req1_b,
  output logic                 dp_sel,
  output logic                 busy,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [NPAIR-1:0]     rsp_flags0,
  output logic [NPAIR-1:0]     rsp_flags1,
  output logic                 rsp_sum0,
  output logic                 rsp_sum1
);

  localparam int W = 2 * NPAIR;

  typedef enum logic [1:0] {S_IDLE, S_EVAL0, S_EVAL1, S_RESP} state_t;

  state_t           state_q;
  logic             rr_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             dp_sel_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [NPAIR-1:0] flags0_q;
  logic [NPAIR-1:0] flags1_q;
  logic             sum0_q;
  logic             sum1_q;

  function automatic logic [NPAIR-1:0] pair_and(input logic [W-1:0] x);
    logic [NPAIR-1:0] f;
    for (int k = 0; k < NPAIR; k++) f[k] = x[2*k] & x[2*k+1];
    return f;
  endfunction

  function automatic logic nand_of_ors(input logic [NPAIR-1:0] f);
    logic acc;
    acc = 1'b1;
    for (int g = 0; g < NPAIR/2; g++) acc = acc & (f[2*g] | f[2*g+1]);
    return ~acc;
  endfunction

  logic             idle;
  logic             gnt_id;
  logic             accept;
  logic [W-1:0]     dp_x;
  logic [NPAIR-1:0] pass_flags;
  logic             pass_sum;

  // Requester 1 wins when it is alone or when the pointer favours it.
  always_comb begin
    idle       = (state_q == S_IDLE) && !rst;
    gnt_id     = req1_valid & (~req0_valid | rr_q);
    req0_ready = idle & req0_valid & ~gnt_id;
    req1_ready = idle & req1_valid & gnt_id;
    accept     = req0_ready | req1_ready;
    dp_x       = dp_sel_q ? b_q : a_q;
    pass_flags = pair_and(dp_x);
    pass_sum   = nand_of_ors(pass_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      dp_sel_q    <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      flags0_q    <= '0;
      flags1_q    <= '0;
      sum0_q      <= 1'b0;
      sum1_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q      <= gnt_id ? req1_a : req0_a;
            b_q      <= gnt_id ? req1_b : req0_b;
            rsp_id_q <= gnt_id;
            rr_q     <= ~gnt_id;
            busy_q   <= 1'b1;
            state_q  <= S_EVAL0;
          end
        end
        // Outputs are registered, so dp_sel is raised on entry to EVAL1.
        S_EVAL0: begin
          flags0_q <= pass_flags;
          sum0_q   <= pass_sum;
          dp_sel_q <= 1'b1;
          state_q  <= S_EVAL1;
        end
        S_EVAL1: begin
          flags1_q    <= pass_flags;
          sum1_q      <= pass_sum;
          dp_sel_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dp_sel     = dp_sel_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_flags0 = flags0_q;
  assign rsp_flags1 = flags1_q;
  assign rsp_sum0   = sum0_q;
  assign rsp_sum1   = sum1_q;

endmodule
